// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// ------------
// Read-side consumer for the 8-bit synchronous byte FIFO. Whenever the FIFO
// reports data, one byte is popped through the read port and sent on a UART
// line as 8N1 (PARITY_EN=0) or 8E1 (PARITY_EN=1), LSB first.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit period (2..65535)
//   PARITY_EN     1 inserts an even-parity bit between data bit 7 and stop
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous, active-high reset
//   fifo_empty  FIFO empty flag
//   fifo_re     FIFO read strobe, registered one-cycle pulse per byte
//   fifo_dout   FIFO read data, only looked at in the capture cycle
//   txd         serial line, idles at mark (1)
//   busy        high whenever the controller is not idle
//   tx_done     one-cycle pulse in the final clock of each stop bit
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    output logic       fifo_re,
    input  logic [7:0] fifo_dout,
    output logic       txd,
    output logic       busy,
    output logic       tx_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST    = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRELAST = BAUD_W'(CLKS_PER_BIT - 2);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CAP,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t            state, state_nx;
    logic [BAUD_W-1:0] baud_cnt, baud_cnt_nx;
    logic [2:0]        bit_cnt, bit_cnt_nx;
    logic [7:0]        shreg, shreg_nx;
    logic              par_bit, par_bit_nx;
    logic              txd_nx;
    logic              fifo_re_nx;
    logic              tx_done_nx;
    logic              baud_tick;

    assign baud_tick = (baud_cnt == BAUD_LAST);
    assign busy      = (state != IDLE);

    // State and output register. Every output except busy is registered so
    // the TX pin and the FIFO strobe are glitch-free; reset returns the line
    // to mark and drops any partially sent byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            txd      <= 1'b1;
            fifo_re  <= 1'b0;
            tx_done  <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
        end else begin
            state    <= state_nx;
            txd      <= txd_nx;
            fifo_re  <= fifo_re_nx;
            tx_done  <= tx_done_nx;
            baud_cnt <= baud_cnt_nx;
            bit_cnt  <= bit_cnt_nx;
            shreg    <= shreg_nx;
            par_bit  <= par_bit_nx;
        end
    end

    // Next-state logic. The baud counter restarts at zero on every bit
    // boundary, so each bit lasts exactly CLKS_PER_BIT cycles. txd is
    // computed one cycle ahead: at a DATA boundary the next bit is shreg[1]
    // because the register shifts on that same edge. tx_done is raised one
    // count early so the registered pulse lands in the last stop-bit clock.
    always_comb begin
        state_nx    = state;
        txd_nx      = txd;
        fifo_re_nx  = 1'b0;
        tx_done_nx  = 1'b0;
        baud_cnt_nx = baud_cnt;
        bit_cnt_nx  = bit_cnt;
        shreg_nx    = shreg;
        par_bit_nx  = par_bit;

        case (state)
            IDLE: begin
                txd_nx      = 1'b1;
                baud_cnt_nx = '0;
                if (!fifo_empty) begin
                    fifo_re_nx = 1'b1;
                    state_nx   = REQ;
                end
            end

            REQ: begin
                state_nx = CAP;
            end

            CAP: begin
                shreg_nx    = fifo_dout;
                par_bit_nx  = ^fifo_dout;
                txd_nx      = 1'b0;
                baud_cnt_nx = '0;
                state_nx    = START;
            end

            START: begin
                if (baud_tick) begin
                    baud_cnt_nx = '0;
                    bit_cnt_nx  = '0;
                    txd_nx      = shreg[0];
                    state_nx    = DATA;
                end else begin
                    baud_cnt_nx = baud_cnt + BAUD_W'(1);
                end
            end

            DATA: begin
                if (baud_tick) begin
                    baud_cnt_nx = '0;
                    shreg_nx    = shreg >> 1;
                    bit_cnt_nx  = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (PARITY_EN != 0) begin
                            txd_nx   = par_bit;
                            state_nx = PAR;
                        end else begin
                            txd_nx   = 1'b1;
                            state_nx = STOP;
                        end
                    end else begin
                        txd_nx = shreg[1];
                    end
                end else begin
                    baud_cnt_nx = baud_cnt + BAUD_W'(1);
                end
            end

            PAR: begin
                if (baud_tick) begin
                    baud_cnt_nx = '0;
                    txd_nx      = 1'b1;
                    state_nx    = STOP;
                end else begin
                    baud_cnt_nx = baud_cnt + BAUD_W'(1);
                end
            end

            STOP: begin
                txd_nx     = 1'b1;
                tx_done_nx = (baud_cnt == BAUD_PRELAST);
                if (baud_tick) begin
                    baud_cnt_nx = '0;
                    state_nx    = IDLE;
                end else begin
                    baud_cnt_nx = baud_cnt + BAUD_W'(1);
                end
            end

            default: begin
                txd_nx   = 1'b1;
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Read-side consumer for the team's 8-bit synchronous FIFO.
- Pops one byte at a time through the FIFO read port (empty/re/dout).
- Serialises each byte onto a UART line: 8N1, or 8E1 when parity is enabled.
- Sits between the byte FIFO and the chip-level TX pin; the writer side of the FIFO is owned by upstream logic.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit period; legal range 2..65535.
- PARITY_EN, 0, 1 inserts an even-parity bit between data bit 7 and the stop bit.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- fifo_empty  input  1  FIFO empty flag.
- fifo_re  output  1  FIFO read strobe; registered, one-cycle pulse per byte.
- fifo_dout  input  8  FIFO read data; valid only in the cycle after the FIFO samples fifo_re high, undefined (may be Z) otherwise.
- txd  output  1  serial line; idle/mark = 1.
- busy  output  1  1 whenever state != IDLE.
- tx_done  output  1  one-cycle pulse at the final clock of each stop bit.

Behaviour:
- Reset, sampled only on a clk edge: state=IDLE, txd=1, fifo_re=0, busy=0, tx_done=0, baud counter=0, bit counter=0, shift register=0.
- Reset mid-frame: the next edge forces txd=1 and IDLE; the partial byte is dropped and not re-read.
- States: IDLE, REQ, CAP, START, DATA, PAR, STOP.
- IDLE: if fifo_empty==0, then fifo_re<=1 and go to REQ; otherwise hold, txd=1.
- REQ: fifo_re<=0; go to CAP. The FIFO samples re=1 on this edge and presents the byte in the following cycle.
- CAP: shift register <= fifo_dout; parity register <= ^fifo_dout; txd<=0; baud counter<=0; go to START.
- START: txd=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit counter=0.
- DATA: txd=shreg[0] (LSB first); each bit lasts CLKS_PER_BIT cycles, then shreg>>=1 and bit counter++. After bit 7, go to PAR if PARITY_EN, else STOP.
- PAR: txd = even-parity bit (XOR of the 8 data bits), held for CLKS_PER_BIT cycles, then go to STOP.
- STOP: txd=1 for CLKS_PER_BIT cycles; tx_done=1 in the last of those cycles; then go to IDLE.
- Baud counter: width clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1; terminal count advances the bit; it reloads to 0 on every bit boundary, with no drift.
- Bit counter: 3 bits; it wraps only by leaving the DATA state.
- Frame length on txd: (10 + PARITY_EN) * CLKS_PER_BIT cycles, from the edge where START begins to the end of STOP.
- Back-to-back bytes: after STOP, the IDLE, REQ and CAP cycles add exactly 3 extra mark cycles between frames. fifo_re is never asserted outside IDLE->REQ.
- fifo_empty is ignored outside IDLE. A write arriving mid-frame is picked up at the next IDLE.
- If fifo_empty deasserts in the same cycle the FSM enters IDLE, it is acted on in that IDLE cycle.
- Only one fifo_re pulse is issued per frame, so at most one byte is popped per frame and no overrun is possible.
- fifo_dout is sampled only in CAP; its value in every other cycle is don't-care (tolerates Z).

Test Plan:
- Reset: hold rst=1 for 3 cycles with fifo_empty=0 -> txd=1, fifo_re=0, busy=0 throughout; after release, fifo_re pulses exactly 1 cycle at the first IDLE edge.
- Single byte, CLKS_PER_BIT=4, PARITY_EN=0, FIFO holds 0xA5 -> txd bit sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 cycles total); tx_done pulses once on cycle 40; busy drops the next cycle.
- Parity, CLKS_PER_BIT=4, PARITY_EN=1, bytes 0xA5 then 0x01 -> parity bits 0 and 1 respectively; frames are 44 cycles each; exactly 3 mark cycles between the two stop bits' end and the next start bit.
- Burst of 16 bytes 0x00..0x0F preloaded in the FIFO -> 16 frames decode in order; exactly 16 fifo_re pulses; FSM idles with busy=0 once fifo_empty=1.
- Mid-frame reset: assert rst during DATA bit 3 of 0x3C -> txd=1 on the next edge; no tx_done; the next FIFO byte is transmitted whole after reset release.
- Empty FIFO with fifo_dout driven Z for 100 cycles -> no fifo_re, txd stays 1, no X propagation into shreg.
